vproc_bus_responder: RTL and testbench

// Target-side end of the VProc bus: decodes Addr/WE/RD from a VProc initiator,

---
 rtl/vproc_resp_pkg.sv | 30 +++
 rtl/vproc_bus_responder_if.sv | 27 ++
 rtl/vproc_resp_ram.sv | 22 ++
 rtl/vproc_bus_responder.sv | 146 ++++++++++++++
 tb/tb_vproc_bus_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vproc_resp_pkg.sv
// Shared types and widths for the VProc bus responder.
// The protocol checks live here so the rule set stays in one place.
package vproc_resp_pkg;

  localparam int WAIT_W  = 4;
  localparam int BURST_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

  // Burst bookkeeping violations for a beat being accepted. A first beat is
  // judged against its own Burst count, so a one-beat burst may carry
  // First and Last together.
  function automatic logic burst_violation(
    input logic               first,
    input logic               last,
    input logic [BURST_W-1:0] burst,
    input logic [BURST_W-1:0] bcnt
  );
    logic [BURST_W-1:0] remaining;
    remaining = first ? burst : bcnt;
    return (last && (remaining != BURST_W'(1)))
        || (first && (burst == '0))
        || (!first && (bcnt == '0) && (burst != '0));
  endfunction

endpackage

// File: rtl/vproc_bus_responder_if.sv
// VProc bus signal bundle between an initiator (master) and a responder (slave).
interface vproc_bus_responder_if;
  import vproc_resp_pkg::*;

  logic [31:0]        Addr;
  logic               WE;
  logic               RD;
  logic [31:0]        DataIn;
  logic [BURST_W-1:0] Burst;
  logic               BurstFirst;
  logic               BurstLast;
  logic [31:0]        DataOut;
  logic               WRAck;
  logic               RDAck;
  logic               Err;

  modport master (
    output Addr, WE, RD, DataIn, Burst, BurstFirst, BurstLast,
    input  DataOut, WRAck, RDAck, Err
  );

  modport slave (
    input  Addr, WE, RD, DataIn, Burst, BurstFirst, BurstLast,
    output DataOut, WRAck, RDAck, Err
  );

endinterface

// File: rtl/vproc_resp_ram.sv
// Single-port 32-bit word RAM with registered read; contents survive reset.
module vproc_resp_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Read-first: a same-cycle write returns the previous word.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/vproc_bus_responder.sv
// VProc target: window decode, programmable wait states, one ack per beat,
// local word RAM and sticky protocol-error tracking.
module vproc_bus_responder
  import vproc_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  Clk,
  input  logic                  nReset,
  vproc_bus_responder_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  resp_state_t           state_reg, state_next;
  logic [WAIT_W-1:0]     wcnt_reg, wcnt_next;
  logic [BURST_W-1:0]    bcnt_reg, bcnt_next;
  logic                  err_reg, err_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           data_reg;
  logic                  we_reg;
  logic                  rd_reg;
  logic [31:0]           dout_hold_reg;

  logic                  hit;
  logic                  sel;
  logic                  accept;
  logic                  wr_ack;
  logic                  rd_ack;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  assign hit    = (bus.Addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign sel    = (bus.WE | bus.RD) & hit;
  assign accept = (state_reg == IDLE) & sel;

  vproc_resp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .Clk   (Clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (WAIT_LOAD == '0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (wcnt_reg == WAIT_W'(1)) begin
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM access happens on the edge that enters ACK, so with no wait
  // states the live bus fields must feed the RAM instead of the latches.
  always_comb begin
    wr_ack    = (state_reg == ACK) & we_reg;
    rd_ack    = (state_reg == ACK) & rd_reg;
    ram_we    = 1'b0;
    ram_idx   = addr_reg;
    ram_wdata = data_reg;
    if (state_reg == IDLE) begin
      ram_idx   = bus.Addr[ADDR_WIDTH-1:0];
      ram_wdata = bus.DataIn;
      ram_we    = accept & bus.WE & (state_next == ACK);
    end else if (state_reg == WAIT) begin
      ram_we    = we_reg & (state_next == ACK);
    end
  end

  assign bus.WRAck   = wr_ack;
  assign bus.RDAck   = rd_ack;
  assign bus.DataOut = rd_ack ? ram_rdata : dout_hold_reg;
  assign bus.Err     = err_reg;

  always_comb begin
    wcnt_next = wcnt_reg;
    bcnt_next = bcnt_reg;
    err_next  = err_reg;
    if (accept) begin
      wcnt_next = WAIT_LOAD;
      if (bus.BurstFirst) begin
        bcnt_next = bus.Burst;
      end
      if ((bus.WE & bus.RD)
          | burst_violation(bus.BurstFirst, bus.BurstLast, bus.Burst, bcnt_reg)) begin
        err_next = 1'b1;
      end
    end else if (state_reg == WAIT) begin
      wcnt_next = wcnt_reg - WAIT_W'(1);
    end else if ((state_reg == ACK) && (bcnt_reg != '0)) begin
      bcnt_next = bcnt_reg - BURST_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      wcnt_reg      <= '0;
      bcnt_reg      <= '0;
      err_reg       <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      we_reg        <= 1'b0;
      rd_reg        <= 1'b0;
      dout_hold_reg <= '0;
    end else begin
      wcnt_reg <= wcnt_next;
      bcnt_reg <= bcnt_next;
      err_reg  <= err_next;
      if (accept) begin
        addr_reg <= bus.Addr[ADDR_WIDTH-1:0];
        data_reg <= bus.DataIn;
        we_reg   <= bus.WE;
        // A simultaneous read and write runs as a write only.
        rd_reg   <= bus.RD & ~bus.WE;
      end
      if (rd_ack) begin
        dout_hold_reg <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vproc_bus_responder.sv
// Directed bench: three responders (0 waits, 3 waits, offset window with 1 wait)
// driven from one stimulus set, selected per transaction.
module tb_vproc_bus_responder;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  int          sel;
  logic [31:0] addr, din;
  logic        we, rd, bfirst, blast;
  logic [11:0] burst;

  logic        wrack_m, rdack_m, err_m;
  logic [31:0] dout_m;

  int checks = 0;
  int errors = 0;

  vproc_bus_responder_if if0 ();
  vproc_bus_responder_if if1 ();
  vproc_bus_responder_if if2 ();

  assign if0.Addr = addr;  assign if0.DataIn = din;  assign if0.Burst = burst;
  assign if0.BurstFirst = bfirst;  assign if0.BurstLast = blast;
  assign if0.WE = we & (sel == 0);  assign if0.RD = rd & (sel == 0);

  assign if1.Addr = addr;  assign if1.DataIn = din;  assign if1.Burst = burst;
  assign if1.BurstFirst = bfirst;  assign if1.BurstLast = blast;
  assign if1.WE = we & (sel == 1);  assign if1.RD = rd & (sel == 1);

  assign if2.Addr = addr;  assign if2.DataIn = din;  assign if2.Burst = burst;
  assign if2.BurstFirst = bfirst;  assign if2.BurstLast = blast;
  assign if2.WE = we & (sel == 2);  assign if2.RD = rd & (sel == 2);

  vproc_bus_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .nReset(nReset), .bus(if0));
  vproc_bus_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut1 (
    .Clk(Clk), .nReset(nReset), .bus(if1));
  vproc_bus_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000), .WAIT_STATES(1)) dut2 (
    .Clk(Clk), .nReset(nReset), .bus(if2));

  always_comb begin
    wrack_m = if0.WRAck;  rdack_m = if0.RDAck;  dout_m = if0.DataOut;  err_m = if0.Err;
    if (sel == 1) begin
      wrack_m = if1.WRAck;  rdack_m = if1.RDAck;  dout_m = if1.DataOut;  err_m = if1.Err;
    end else if (sel == 2) begin
      wrack_m = if2.WRAck;  rdack_m = if2.RDAck;  dout_m = if2.DataOut;  err_m = if2.Err;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        rst;
    int          s;
    logic        w, r;
    logic [31:0] a, d;
    logic [11:0] b;
    logic        bf, bl;
    logic        ewr, erd;
    logic [31:0] edout;
    logic        eerr;
    int          elat;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  logic        gw, gr;
  logic [31:0] gd;
  int          gl;
  int          first_k, second_k, acks;

  task automatic pulse_reset();
    we = 1'b0;  rd = 1'b0;  bfirst = 1'b0;  blast = 1'b0;
    nReset = 1'b0;
    @(posedge Clk); #1;
    nReset = 1'b1;
  endtask

  // Holds the request until the ack is seen, keeps it over the sampling
  // edge like a real initiator, then releases; 20-cycle bound per access.
  task automatic run_access(input int s, input logic w, input logic r,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [11:0] b, input logic bf, input logic bl,
                            output logic o_wr, output logic o_rd,
                            output logic [31:0] o_dout, output int o_lat);
    sel = s;  addr = a;  din = d;  burst = b;  bfirst = bf;  blast = bl;
    we = w;  rd = r;
    o_wr = 1'b0;  o_rd = 1'b0;  o_dout = '0;  o_lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      if (wrack_m || rdack_m) begin
        o_wr = wrack_m;  o_rd = rdack_m;  o_dout = dout_m;  o_lat = k;
        break;
      end
    end
    if (o_lat >= 0) begin
      @(posedge Clk); #1;
      chk("ack_single_cycle", 32'({wrack_m, rdack_m}), 32'h0);
    end
    we = 1'b0;  rd = 1'b0;  bfirst = 1'b0;  blast = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 0;  addr = '0;  din = '0;  burst = '0;
    we = 1'b0;  rd = 1'b0;  bfirst = 1'b0;  blast = 1'b0;

    //            rst s  w  r  addr          data          burst  bf bl  ewr erd edout         eerr lat
    vt[0]  = '{1'b0, 0, 1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[1]  = '{1'b0, 0, 1'b0, 1'b1, 32'h10,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 0};
    vt[2]  = '{1'b0, 0, 1'b1, 1'b0, 32'h20,   32'h1000,     12'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[3]  = '{1'b0, 0, 1'b1, 1'b0, 32'h21,   32'h1001,     12'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[4]  = '{1'b0, 0, 1'b1, 1'b0, 32'h22,   32'h1002,     12'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[5]  = '{1'b0, 0, 1'b1, 1'b0, 32'h23,   32'h1003,     12'd4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[6]  = '{1'b0, 0, 1'b0, 1'b1, 32'h20,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000,     1'b0, 0};
    vt[7]  = '{1'b0, 0, 1'b0, 1'b1, 32'h21,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1001,     1'b0, 0};
    vt[8]  = '{1'b0, 0, 1'b0, 1'b1, 32'h22,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1002,     1'b0, 0};
    vt[9]  = '{1'b0, 0, 1'b0, 1'b1, 32'h23,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1003,     1'b0, 0};
    vt[10] = '{1'b0, 1, 1'b1, 1'b0, 32'h44,   32'h12345678, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3};
    vt[11] = '{1'b0, 1, 1'b0, 1'b1, 32'h44,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 3};
    vt[12] = '{1'b0, 2, 1'b1, 1'b0, 32'h1005, 32'hA5A5A5A5, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1};
    vt[13] = '{1'b0, 2, 1'b0, 1'b1, 32'h1005, 32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1};
    vt[14] = '{1'b0, 2, 1'b0, 1'b1, 32'h0005, 32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, -1};
    vt[15] = '{1'b0, 2, 1'b1, 1'b0, 32'h1405, 32'h77,       12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, -1};
    vt[16] = '{1'b0, 0, 1'b1, 1'b0, 32'h30,   32'h3000,     12'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[17] = '{1'b0, 0, 1'b1, 1'b0, 32'h31,   32'h3001,     12'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0};
    vt[18] = '{1'b0, 0, 1'b1, 1'b0, 32'h32,   32'h3002,     12'd4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 0};
    vt[19] = '{1'b0, 0, 1'b0, 1'b1, 32'h10,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 0};
    vt[20] = '{1'b1, 0, 1'b1, 1'b1, 32'h50,   32'h55,       12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 0};
    vt[21] = '{1'b1, 1, 1'b1, 1'b0, 32'h60,   32'h66,       12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 3};
    vt[22] = '{1'b1, 0, 1'b1, 1'b0, 32'h70,   32'h77,       12'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 0};
    vt[23] = '{1'b1, 0, 1'b0, 1'b1, 32'h50,   32'h0,        12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55,       1'b0, 0};

    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
    chk("rst0_outs", 32'({if0.WRAck, if0.RDAck, if0.Err}), 32'h0);
    chk("rst0_dout", if0.DataOut, 32'h0);
    chk("rst1_outs", 32'({if1.WRAck, if1.RDAck, if1.Err}), 32'h0);
    chk("rst1_dout", if1.DataOut, 32'h0);
    chk("rst2_outs", 32'({if2.WRAck, if2.RDAck, if2.Err}), 32'h0);
    chk("rst2_dout", if2.DataOut, 32'h0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst) pulse_reset();
      run_access(vt[i].s, vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].b, vt[i].bf, vt[i].bl,
                 gw, gr, gd, gl);
      $display("vec %0d dut%0d we=%0b rd=%0b addr=0x%08h -> wrack=%0b rdack=%0b dout=0x%08h lat=%0d err=%0b",
               i, vt[i].s, vt[i].w, vt[i].r, vt[i].a, gw, gr, gd, gl, err_m);
      chk($sformatf("v%0d_wrack", i), 32'(gw), 32'(vt[i].ewr));
      chk($sformatf("v%0d_rdack", i), 32'(gr), 32'(vt[i].erd));
      chk($sformatf("v%0d_lat", i), gl, vt[i].elat);
      chk($sformatf("v%0d_err", i), 32'(err_m), 32'(vt[i].eerr));
      if (vt[i].erd) chk($sformatf("v%0d_dout", i), gd, vt[i].edout);
    end

    // Back-to-back reads on the 3-wait responder with RD held high.
    sel = 1;  addr = 32'h44;  burst = '0;  rd = 1'b1;
    first_k = -1;  second_k = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk); #1;
      if (rdack_m) begin
        if (first_k < 0) first_k = k;
        else begin
          second_k = k;
          break;
        end
      end
    end
    @(posedge Clk); #1;
    rd = 1'b0;
    $display("b2b dut1 first_ack=%0d second_ack=%0d", first_k, second_k);
    chk("b2b_first_lat", first_k, 3);
    chk("b2b_period", second_k - first_k, 5);

    // Reset while the write is waiting: no ack, RAM word untouched.
    sel = 1;  addr = 32'h44;  din = 32'hBAD0BAD0;  we = 1'b1;
    @(posedge Clk); #1;
    chk("rstw_no_early_ack", 32'({wrack_m, rdack_m}), 32'h0);
    nReset = 1'b0;
    @(posedge Clk); #1;
    nReset = 1'b1;  we = 1'b0;
    chk("rstw_err", 32'(err_m), 32'h0);
    chk("rstw_dout", dout_m, 32'h0);
    acks = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (wrack_m || rdack_m) acks++;
    end
    $display("rstw dut1 acks_after_reset=%0d", acks);
    chk("rstw_no_ack", acks, 0);
    run_access(1, 1'b0, 1'b1, 32'h44, 32'h0, 12'd0, 1'b0, 1'b0, gw, gr, gd, gl);
    $display("rstw readback dut1 addr=0x00000044 -> rdack=%0b dout=0x%08h lat=%0d", gr, gd, gl);
    chk("rstw_rb_rdack", 32'(gr), 32'h1);
    chk("rstw_rb_dout", gd, 32'h12345678);
    chk("rstw_rb_lat", gl, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
